level_timer_ctrl: RTL and testbench

LEVEL_TIMER_CTRL -- requirements
Module: level_timer_ctrl

---
 rtl/level_timer_ctrl.sv | 143 ++++++++++++++
 tb/tb_level_timer_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_timer_ctrl.sv
// rtl/level_timer_ctrl.sv - level countdown timer with pause, bonus time and score tally
// Remaining seconds are held in binary and shown as two BCD digits.
module level_timer_ctrl #(
    parameter int START_SECS = 60,
    parameter int WARN_SECS  = 10,
    parameter int BONUS_SECS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec,
    input  logic       start,
    input  logic       pause_req,
    input  logic       bonus,
    input  logic       level_done,
    output logic       turbo,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       warn,
    output logic       timeout,
    output logic       score_pulse,
    output logic       tally_done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PAUSED  = 3'd2,
        S_TALLY   = 3'd3,
        S_EXPIRED = 3'd4
    } state_t;

    localparam logic [6:0] START_C = 7'(START_SECS);
    localparam logic [6:0] WARN_C  = 7'(WARN_SECS);
    localparam logic [7:0] BONUS_C = 8'(BONUS_SECS);
    localparam logic [7:0] MAX_C   = 8'd99;

    state_t     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic       timeout_q, timeout_d;
    logic       score_q, score_d;
    logic       tally_done_q, tally_done_d;

    logic [6:0] count_dec;
    logic [6:0] bonus_base;
    logic [7:0] bonus_sum;
    logic [6:0] bonus_sat;
    logic       run_tick;

    // A RUN tick with no pause/level_done decrements first, then the bonus is added on top.
    always_comb begin
        run_tick   = (state_q == S_RUN) && one_sec && !pause_req && !level_done;
        count_dec  = count_q - 7'd1;
        bonus_base = run_tick ? count_dec : count_q;
        bonus_sum  = {1'b0, bonus_base} + BONUS_C;
        bonus_sat  = (bonus_sum > MAX_C) ? 7'd99 : bonus_sum[6:0];
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        timeout_d    = 1'b0;
        score_d      = 1'b0;
        tally_done_d = 1'b0;
        case (state_q)
            S_IDLE, S_EXPIRED: begin
                if (start) begin
                    state_d = S_RUN;
                    count_d = START_C;
                end
            end
            S_RUN: begin
                if (level_done) begin
                    state_d = S_TALLY;
                end else if (pause_req) begin
                    state_d = S_PAUSED;
                    if (bonus) count_d = bonus_sat;
                end else if (one_sec) begin
                    count_d = bonus ? bonus_sat : count_dec;
                    if (!bonus && count_q == 7'd1) begin
                        state_d   = S_EXPIRED;
                        timeout_d = 1'b1;
                    end
                end else if (bonus) begin
                    count_d = bonus_sat;
                end
            end
            S_PAUSED: begin
                if (bonus) count_d = bonus_sat;
                if (!pause_req) state_d = S_RUN;
            end
            S_TALLY: begin
                if (count_q == 7'd0) begin
                    state_d      = S_IDLE;
                    tally_done_d = 1'b1;
                end else if (one_sec) begin
                    count_d = count_dec;
                    score_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 7'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= 7'd0;
            timeout_q    <= 1'b0;
            score_q      <= 1'b0;
            tally_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timeout_q    <= timeout_d;
            score_q      <= score_d;
            tally_done_q <= tally_done_d;
        end
    end

    logic [3:0] tens;

    always_comb begin
        tens = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (count_q >= 7'(i * 10)) tens = 4'(i);
        end
    end

    assign secs_tens   = tens;
    assign secs_ones   = 4'(count_q - 7'(tens) * 7'd10);
    assign turbo       = (state_q == S_TALLY);
    assign warn        = ((state_q == S_RUN) || (state_q == S_PAUSED)) &&
                         (count_q != 7'd0) && (count_q <= WARN_C);
    assign timeout     = timeout_q;
    assign score_pulse = score_q;
    assign tally_done  = tally_done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_level_timer_ctrl.sv
// tb/tb_level_timer_ctrl.sv - directed and randomized checks of level_timer_ctrl
module tb_level_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one_sec = 1'b0;
    logic       start = 1'b0;
    logic       pause_req = 1'b0;
    logic       bonus = 1'b0;
    logic       level_done = 1'b0;
    logic       turbo;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       warn;
    logic       timeout;
    logic       score_pulse;
    logic       tally_done;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: state number, remaining seconds and last-cycle pulses
    int m_st = 0;
    int m_cnt = 0;
    int m_to = 0;
    int m_sp = 0;
    int m_td = 0;

    level_timer_ctrl #(.START_SECS(60), .WARN_SECS(10), .BONUS_SECS(5)) dut (
        .clk(clk), .reset(reset), .one_sec(one_sec), .start(start),
        .pause_req(pause_req), .bonus(bonus), .level_done(level_done),
        .turbo(turbo), .secs_tens(secs_tens), .secs_ones(secs_ones),
        .warn(warn), .timeout(timeout), .score_pulse(score_pulse),
        .tally_done(tally_done), .state(state)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {state, secs_tens, secs_ones, warn, timeout, score_pulse, tally_done, turbo};

    function automatic int sat99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic logic [15:0] exp_obs();
        logic [2:0] s;
        logic [3:0] t, o;
        logic w, tu;
        s  = 3'(m_st);
        t  = 4'(m_cnt / 10);
        o  = 4'(m_cnt % 10);
        w  = (m_st == 1 || m_st == 2) && m_cnt > 0 && m_cnt <= 10;
        tu = (m_st == 3);
        return {s, t, o, w, m_to != 0, m_sp != 0, m_td != 0, tu};
    endfunction

    task automatic model_step(input logic r, s, os, pr, b, ld);
        m_to = 0; m_sp = 0; m_td = 0;
        if (r) begin
            m_st = 0; m_cnt = 0;
        end else begin
            case (m_st)
                0, 4: if (s) begin m_st = 1; m_cnt = 60; end
                1: begin
                    if (ld) m_st = 3;
                    else if (pr) begin
                        m_st = 2;
                        if (b) m_cnt = sat99(m_cnt + 5);
                    end else if (os) begin
                        m_cnt = sat99(m_cnt - 1 + (b ? 5 : 0));
                        if (m_cnt == 0) begin m_st = 4; m_to = 1; end
                    end else if (b) m_cnt = sat99(m_cnt + 5);
                end
                2: begin
                    if (b) m_cnt = sat99(m_cnt + 5);
                    if (!pr) m_st = 1;
                end
                3: begin
                    if (m_cnt == 0) begin m_st = 0; m_td = 1; end
                    else if (os) begin m_cnt = m_cnt - 1; m_sp = 1; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic r, s, os, pr, b, ld);
        reset = r; start = s; one_sec = os; pause_req = pr; bonus = b; level_done = ld;
        @(posedge clk);
        model_step(r, s, os, pr, b, ld);
        #1;
        reset = 0; start = 0; one_sec = 0; pause_req = 0; bonus = 0; level_done = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 1, 1, 1);
        n_vec++;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", obs, 16'h0000);
        end
    endtask

    task automatic test_countdown();
        int to_cnt = 0;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        n_vec++;
        if ({state, secs_tens, secs_ones} !== {3'd1, 4'd6, 4'd0}) begin
            n_err++;
            $display("FAIL countdown_load: got %h want %h", {state, secs_tens, secs_ones}, {3'd1, 4'd6, 4'd0});
        end
        for (int k = 59; k >= 0; k--) begin
            cycle(0, 0, 1, 0, 0, 0);
            to_cnt += int'(timeout);
            n_vec++;
            if ({secs_tens, secs_ones, warn} !== {4'(k / 10), 4'(k % 10), 1'(k >= 1 && k <= 10)}) begin
                n_err++;
                $display("FAIL countdown_k%0d: got %h want %h", k, {secs_tens, secs_ones, warn},
                         {4'(k / 10), 4'(k % 10), 1'(k >= 1 && k <= 10)});
            end
        end
        cycle(0, 0, 1, 0, 0, 0);
        to_cnt += int'(timeout);
        n_vec++;
        if (to_cnt != 1 || state !== 3'd4) begin
            n_err++;
            $display("FAIL countdown_expire: got timeouts=%0d state=%0d want 1 and 4", to_cnt, state);
        end
    endtask

    task automatic test_pause();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        ticks(35);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0);
        n_vec++;
        if ({state, secs_tens, secs_ones} !== {3'd2, 4'd2, 4'd5}) begin
            n_err++;
            $display("FAIL pause_hold: got %h want %h", {state, secs_tens, secs_ones}, {3'd2, 4'd2, 4'd5});
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        n_vec++;
        if ({state, secs_tens, secs_ones} !== {3'd1, 4'd2, 4'd4}) begin
            n_err++;
            $display("FAIL pause_release: got %h want %h", {state, secs_tens, secs_ones}, {3'd1, 4'd2, 4'd4});
        end
    endtask

    task automatic test_bonus_sat();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0);
        n_vec++;
        if ({secs_tens, secs_ones} !== {4'd9, 4'd9}) begin
            n_err++;
            $display("FAIL bonus_cap: got %h want 99", {secs_tens, secs_ones});
        end
        ticks(2);
        n_vec++;
        if ({secs_tens, secs_ones} !== {4'd9, 4'd7}) begin
            n_err++;
            $display("FAIL bonus_97: got %h want 97", {secs_tens, secs_ones});
        end
        cycle(0, 0, 1, 0, 1, 0);
        n_vec++;
        if ({state, secs_tens, secs_ones} !== {3'd1, 4'd9, 4'd9}) begin
            n_err++;
            $display("FAIL bonus_tick_sat: got %h want %h", {state, secs_tens, secs_ones}, {3'd1, 4'd9, 4'd9});
        end
    endtask

    task automatic test_tally();
        int sp_cnt = 0;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        ticks(48);
        cycle(0, 0, 1, 0, 1, 1);
        n_vec++;
        if ({state, turbo, secs_tens, secs_ones} !== {3'd3, 1'b1, 4'd1, 4'd2}) begin
            n_err++;
            $display("FAIL tally_enter: got %h want %h", {state, turbo, secs_tens, secs_ones}, {3'd3, 1'b1, 4'd1, 4'd2});
        end
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 1, 0, 1, 0);
            sp_cnt += int'(score_pulse);
        end
        cycle(0, 0, 0, 0, 0, 0);
        sp_cnt += int'(score_pulse);
        n_vec++;
        if (sp_cnt != 12 || {tally_done, state, turbo} !== {1'b1, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL tally_finish: got pulses=%0d td/state/turbo=%h want 12 and %h",
                     sp_cnt, {tally_done, state, turbo}, {1'b1, 3'd0, 1'b0});
        end
    endtask

    task automatic test_tally_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        ticks(53);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 1, 0, 0, 0);
        n_vec++;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL tally_reset: got %h want %h", obs, 16'h0000);
        end
    endtask

    task automatic test_expired();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        ticks(60);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 0, 1);
        n_vec++;
        if ({state, secs_tens, secs_ones, timeout} !== {3'd4, 4'd0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL expired_ignore: got %h want %h", {state, secs_tens, secs_ones, timeout}, {3'd4, 4'd0, 4'd0, 1'b0});
        end
        cycle(0, 1, 0, 0, 0, 0);
        n_vec++;
        if ({state, secs_tens, secs_ones} !== {3'd1, 4'd6, 4'd0}) begin
            n_err++;
            $display("FAIL expired_restart: got %h want %h", {state, secs_tens, secs_ones}, {3'd1, 4'd6, 4'd0});
        end
    endtask

    task automatic test_random();
        logic r, s, os, pr, b, ld;
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom % 300) == 0;
            s  = ($urandom % 25) == 0;
            os = ($urandom % 3) == 0;
            pr = ($urandom % 6) == 0;
            b  = ($urandom % 8) == 0;
            ld = ($urandom % 60) == 0;
            cycle(r, s, os, pr, b, ld);
            n_vec++;
            if (obs !== exp_obs()) begin
                n_err++;
                $display("FAIL random_%0d: got %h want %h", i, obs, exp_obs());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_countdown();
        test_pause();
        test_bonus_sat();
        test_tally();
        test_tally_reset();
        test_expired();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
